// File: rtl/add51_share_arbiter.sv
// Two requesters share one 51+34-bit adder. Round-robin grant, one registered
// result slot per requester, and per-requester completion counters.
module add51_share_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [50:0]      req0_a,
  input  logic [33:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [50:0]      req1_a,
  input  logic [33:0]      req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [51:0]      rsp0_sum,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [51:0]      rsp1_sum,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt,
  output logic             prio
);

  logic             elig0, elig1;
  logic             grant0, grant1;
  logic [50:0]      op_a;
  logic [33:0]      op_b;
  logic [51:0]      sum;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [51:0]      rsp0_sum_q, rsp0_sum_d;
  logic [51:0]      rsp1_sum_q, rsp1_sum_d;
  logic [CNT_W-1:0] done0_cnt_q, done0_cnt_d;
  logic [CNT_W-1:0] done1_cnt_q, done1_cnt_d;
  logic             prio_q, prio_d;
  logic             drain0, drain1;

  // A slot that drains this cycle counts as free, so a requester can refill it.
  always_comb begin
    drain0 = rsp0_valid_q & rsp0_ready;
    drain1 = rsp1_valid_q & rsp1_ready;
    elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
    grant0 = ~rst & elig0 & (~elig1 | ~prio_q);
    grant1 = ~rst & elig1 & (~elig0 | prio_q);
  end

  // Shared adder; B is zero-extended, the carry lands in bit 51.
  always_comb begin
    op_a = grant1 ? req1_a : req0_a;
    op_b = grant1 ? req1_b : req0_b;
    sum  = {1'b0, op_a} + {18'b0, op_b};
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_sum_d   = rsp0_sum_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_sum_d   = rsp1_sum_q;
    done0_cnt_d  = done0_cnt_q;
    done1_cnt_d  = done1_cnt_q;
    prio_d       = prio_q;

    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_sum_d   = sum;
    end else if (drain0) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_sum_d   = sum;
    end else if (drain1) begin
      rsp1_valid_d = 1'b0;
    end

    if (drain0) done0_cnt_d = done0_cnt_q + 1'b1;
    if (drain1) done1_cnt_d = done1_cnt_q + 1'b1;

    // Priority moves away from whoever was served, even if it was alone.
    if (grant0)      prio_d = 1'b1;
    else if (grant1) prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q   <= '0;
      rsp1_sum_q   <= '0;
      done0_cnt_q  <= '0;
      done1_cnt_q  <= '0;
      prio_q       <= 1'b0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_sum_q   <= rsp0_sum_d;
      rsp1_sum_q   <= rsp1_sum_d;
      done0_cnt_q  <= done0_cnt_d;
      done1_cnt_q  <= done1_cnt_d;
      prio_q       <= prio_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign done0_cnt  = done0_cnt_q;
  assign done1_cnt  = done1_cnt_q;
  assign prio       = prio_q;

endmodule

// File: tb/tb_add51_share_arbiter.sv
// Bench for add51_share_arbiter: directed steps plus random traffic, checked
// against a transaction-level model of the two result slots.
module tb_add51_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [50:0] req0_a, req1_a;
  logic [33:0] req0_b, req1_b;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, prio;
  logic [51:0] rsp0_sum, rsp1_sum;
  logic [3:0]  done0_cnt, done1_cnt;

  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_prio;
  logic [51:0] w_rsp0_sum, w_rsp1_sum;
  logic [15:0] w_done0_cnt, w_done1_cnt;

  int compared = 0;
  int mismatched = 0;

  // Reference state: what each requester is owed, and the served counts.
  logic        m_valid [2];
  logic [51:0] m_sum   [2];
  int          m_done  [2];
  logic        m_prio;
  logic        m_grant [2];

  always #5 clk = ~clk;

  add51_share_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
    .done0_cnt(done0_cnt), .done1_cnt(done1_cnt), .prio(prio)
  );

  add51_share_arbiter dut_wide (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(w_rsp0_sum),
    .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(w_rsp1_sum),
    .done0_cnt(w_done0_cnt), .done1_cnt(w_done1_cnt), .prio(w_prio)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] ref_sum(input logic [50:0] a, input logic [33:0] b);
    return 52'(a) + 52'(b);
  endfunction

  // Who should be served this cycle, from the arbitration rules.
  task automatic model_grant();
    logic v [2];
    logic r [2];
    logic elig [2];
    v[0] = req0_valid; v[1] = req1_valid;
    r[0] = rsp0_ready; r[1] = rsp1_ready;
    for (int i = 0; i < 2; i++) begin
      elig[i]    = v[i] && (!m_valid[i] || r[i]);
      m_grant[i] = 1'b0;
    end
    if (!rst) begin
      if (elig[0] && elig[1]) m_grant[m_prio] = 1'b1;
      else if (elig[0])       m_grant[0] = 1'b1;
      else if (elig[1])       m_grant[1] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic r [2];
    r[0] = rsp0_ready; r[1] = rsp1_ready;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0; m_sum[i] = '0; m_done[i] = 0;
      end
      m_prio = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && r[i]) m_done[i]++;
      if (m_grant[i]) begin
        m_valid[i] = 1'b1;
        m_sum[i]   = (i == 0) ? ref_sum(req0_a, req0_b) : ref_sum(req1_a, req1_b);
      end else if (m_valid[i] && r[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (m_grant[0])      m_prio = 1'b1;
    else if (m_grant[1]) m_prio = 1'b0;
  endtask

  task automatic check_all();
    chk("req0_ready", 64'(req0_ready), 64'(m_grant[0]));
    chk("req1_ready", 64'(req1_ready), 64'(m_grant[1]));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(m_valid[0]));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(m_valid[1]));
    chk("rsp0_sum", 64'(rsp0_sum), 64'(m_sum[0]));
    chk("rsp1_sum", 64'(rsp1_sum), 64'(m_sum[1]));
    chk("prio", 64'(prio), 64'(m_prio));
    chk("done0_cnt4", 64'(done0_cnt), 64'(m_done[0] % 16));
    chk("done1_cnt4", 64'(done1_cnt), 64'(m_done[1] % 16));
    chk("done0_cnt16", 64'(w_done0_cnt), 64'(m_done[0] % 65536));
    chk("done1_cnt16", 64'(w_done1_cnt), 64'(m_done[1] % 65536));
    chk("wide_match", 64'({w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_prio}),
        64'({m_grant[0], m_grant[1], m_valid[0], m_valid[1], m_prio}));
  endtask

  // Inputs are already set; check at the falling edge, advance model at the rising one.
  task automatic cycle();
    @(negedge clk);
    model_grant();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [51:0] held;
    logic [63:0] t64;
    m_prio = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'bx; m_sum[i] = 'x; m_done[i] = 0;
    end
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held with both requesters asking.
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_reset(3);
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("rst_done0", 64'(done0_cnt), 64'd0);
    chk("rst_prio", 64'(prio), 64'd0);
    #1;
    chk("post_rst_req0_first", 64'(req0_ready), 64'd1);
    cycle();

    // Single op with maximum operands.
    do_reset(1);
    idle_inputs();
    req0_valid = 1'b1; req0_a = 51'h7FFFFFFFFFFFF; req0_b = 34'h3FFFFFFFF;
    #1;
    chk("single_ready", 64'(req0_ready), 64'd1);
    cycle();
    chk("single_valid", 64'(rsp0_valid), 64'd1);
    chk("single_sum", 64'(rsp0_sum), 64'h8_0003_FFFF_FFFE);
    req0_valid = 1'b0;
    cycle();
    chk("single_done", 64'(done0_cnt), 64'd1);

    // Contention: strict alternation from a clean priority.
    do_reset(1);
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_a = 51'(k); req0_b = 34'(k * 3); req1_a = 51'(k + 100); req1_b = 34'(k);
      #1;
      chk("cont_req0", 64'(req0_ready), 64'((k % 2) == 0));
      chk("cont_req1", 64'(req1_ready), 64'((k % 2) == 1));
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();
    chk("cont_done0", 64'(done0_cnt), 64'd3);
    chk("cont_done1", 64'(done1_cnt), 64'd3);

    // Backpressure on slot 0: no head-of-line blocking for requester 1.
    do_reset(1);
    idle_inputs();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 51'h123456789ABCD; req0_b = 34'h2_DEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      req1_a = 51'(k * 7); req1_b = 34'(k + 1);
      #1;
      chk("bp_req0", 64'(req0_ready), 64'(k == 0));
      chk("bp_req1", 64'(req1_ready), 64'(k != 0));
      cycle();
      if (k == 0) held = rsp0_sum;
      req0_a = 51'(k + 9);
    end
    chk("bp_sum_stable", 64'(rsp0_sum), 64'(ref_sum(51'h123456789ABCD, 34'h2_DEAD_BEEF)));
    chk("bp_sum_held", 64'(rsp0_sum), 64'(held));
    rsp0_ready = 1'b1;
    #1;
    chk("bp_refill", 64'(req0_ready), 64'd1);
    cycle();

    // Reset while a result is still pending.
    do_reset(1);
    idle_inputs();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 51'd5; req1_b = 34'd7;
    cycle();
    chk("mid_pending", 64'(rsp1_sum), 64'd12);
    req1_valid = 1'b0;
    do_reset(1);
    chk("mid_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("mid_done1", 64'(done1_cnt), 64'd0);

    // Counter wrap on the 4-bit instance.
    idle_inputs();
    req0_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req0_a = 51'(k); cycle();
    end
    req0_valid = 1'b0;
    cycle();
    chk("wrap_done0_4b", 64'(done0_cnt), 64'd1);
    chk("wrap_done0_16b", 64'(w_done0_cnt), 64'd17);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      rsp0_ready = $urandom_range(0, 2) != 0;
      rsp1_ready = $urandom_range(0, 2) != 0;
      t64 = {$urandom(), $urandom()}; req0_a = t64[50:0];
      t64 = {$urandom(), $urandom()}; req0_b = t64[33:0];
      t64 = {$urandom(), $urandom()}; req1_a = t64[50:0];
      t64 = {$urandom(), $urandom()}; req1_b = t64[33:0];
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/add51_share_arbiter.md
Name: add51_share_arbiter

Overview:
- Shares one 51-bit + 34-bit unsigned adder datapath (52-bit sum, B zero-extended by 17 bits) between two requesters, e.g. two partial-product accumulation engines in the multiplier path.
- Round-robin arbitration with valid/ready request handshakes.
- One registered response slot per requester, with independent backpressure.
- Single-cycle issue latency and per-requester completion counters.

Parameters:
- CNT_W, 16, width of each per-requester completion counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  51  requester 0 operand A
- req0_b  in  34  requester 0 operand B (zero-extended to 51 bits)
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- rsp0_valid  out  1  result slot 0 holds a result
- rsp0_ready  in  1  requester 0 consumes its result
- rsp0_sum  out  52  requester 0 result, A + {17'b0,B}
- rsp1_valid, rsp1_ready, rsp1_sum  same as slot 0, for requester 1
- done0_cnt  out  CNT_W  completed-and-consumed operations, requester 0
- done1_cnt  out  CNT_W  completed-and-consumed operations, requester 1
- prio  out  1  current round-robin priority (0 = requester 0 favoured)

Behaviour:
- Reset, synchronous, active-high clk edge with rst=1:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_sum = rsp1_sum = 0.
  - done0_cnt = done1_cnt = 0.
  - prio = 0.
  - rst dominates all other events in that cycle.
  - A result pending at reset is discarded and not counted.
- Eligibility: requester i is eligible when reqi_valid=1 AND (rspi_valid=0 OR rspi_ready=1). Slot draining in the same cycle counts as free.
- Grant, combinational, one per cycle:
  - Only one eligible requester: it is granted.
  - Both eligible: requester `prio` is granted.
  - Neither eligible: no grant.
  - reqi_ready = granti. It is 0 during rst.
  - reqi_ready never asserts without reqi_valid.
- Adder:
  - One shared combinational adder; its inputs are muxed from the granted requester.
  - sum = A + zero_extend(B), 52 bits, carry-out in bit 51. No overflow is possible.
- Issue: on a granted cycle, rspi_sum <= sum and rspi_valid <= 1 at the next edge. Latency is one cycle from accept to rsp valid.
- Response slot i state update per edge:
  - grant_i: valid <= 1, sum <= new result. This applies even if rspi_ready=1 that cycle (drain and refill at once).
  - No grant_i but rspi_valid & rspi_ready: valid <= 0, and sum holds its last value.
  - Otherwise hold.
- rspi_sum and rspi_valid must stay stable while rspi_valid=1 and rspi_ready=0.
- Priority update: after any grant, prio <= the index NOT granted. With no grant, prio holds. When only one requester is eligible, prio still moves away from it.
- Counters: donei_cnt increments on each edge where rspi_valid & rspi_ready. It wraps from 2^CNT_W-1 to 0.
- Throughput:
  - The adder issues at most one result per cycle.
  - Each requester sustains one op per cycle if it is alone and its slot drains every cycle.
  - With both requesters streaming, issues alternate 0,1,0,1.
- Back-to-back hazard: a requester whose slot is full and not draining is skipped. The other requester is granted even if it lacks priority, so there is no head-of-line blocking.
- Inputs reqi_a/reqi_b are only sampled in granted cycles.

Test Plan:
- Reset: hold rst 3 cycles with both reqs valid. Required: all rsp_valid=0, sums=0, counters=0, prio=0, req_ready=0. Release rst: req0 granted first.
- Single op: req0 a=51'h7FFFFFFFFFFFF, b=34'h3FFFFFFFF with rsp0_ready=1. Required: req0_ready=1 in cycle t, rsp0_valid=1 at t+1, rsp0_sum=52'h8000_3FFFF_FFFE, done0_cnt=1 at t+2.
- Contention: both valid for 6 cycles with both rsp_ready=1. Required: grant order 0,1,0,1,0,1, prio toggles each cycle, each counter reaches 3.
- Backpressure: rsp0_ready=0 with req0 valid continuously and req1 valid. Required: req0 granted once, then only req1 granted every cycle. rsp0_sum stable. Raising rsp0_ready lets req0 be granted in the same cycle (drain+refill).
- Mid-operation reset: grant req1 (a=5, b=7), then assert rst on the next edge before it is consumed. Required: rsp1_valid=0 and done1_cnt=0 after reset.
- Counter wrap with CNT_W=4: 17 consumed results on requester 0. Required: done0_cnt reads 1.
